// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 types and widths for the ID/EX operand stage
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SLL   = 4'b0001,
        ALU_SLT   = 4'b0010,
        ALU_SLTU  = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_OR    = 4'b0110,
        ALU_AND   = 4'b0111,
        ALU_SUB   = 4'b1000,
        ALU_PASSB = 4'b1001,
        ALU_SRA   = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        ASEL_RS1  = 2'b00,
        ASEL_PC   = 2'b01,
        ASEL_ZERO = 2'b10,
        ASEL_RSVD = 2'b11
    } asel_e;

    typedef enum logic {
        BSEL_RS2 = 1'b0,
        BSEL_IMM = 1'b1
    } bsel_e;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'b00,
        ST_FULL      = 2'b01,
        ST_INTERLOCK = 2'b10
    } ex_state_e;

endpackage

// File: rtl/fwd_unit.sv
// rtl/fwd_unit.sv - one source-operand forwarding/hazard slice; forwarding enabled by ALU_FWD_EN
module fwd_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [XLEN-1:0]   rs_data,
    input  logic [REG_AW-1:0] mem_rd_addr,
    input  logic              mem_rd_wren,
    input  logic              mem_is_load,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [REG_AW-1:0] wb_rd_addr,
    input  logic              wb_rd_wren,
    input  logic [XLEN-1:0]   wb_data,
    output logic [XLEN-1:0]   fwd_data,
    output logic              hazard
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero, so it never matches a producer
    assign mem_hit = (rs_addr != '0) & mem_rd_wren & (mem_rd_addr == rs_addr);
    assign wb_hit  = (rs_addr != '0) & wb_rd_wren  & (wb_rd_addr  == rs_addr);

`ifdef ALU_FWD_EN
    assign hazard   = mem_hit & mem_is_load;
    assign fwd_data = (mem_hit & ~mem_is_load) ? mem_data :
                      wb_hit                   ? wb_data  : rs_data;
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{mem_is_load, mem_data, wb_data};
    assign hazard   = mem_hit | wb_hit;
    assign fwd_data = rs_data;
`endif

endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with RAW hazard resolution; forwarding enabled by ALU_FWD_EN
module ex_operand_stage
    import rv32_pkg::*;
#(
    parameter int XLEN   = rv32_pkg::XLEN,
    parameter int REG_AW = rv32_pkg::REG_AW
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_id_valid,
    output logic              o_id_ready,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic [XLEN-1:0]   i_imm,
    input  logic [3:0]        i_alu_op,
    input  logic [1:0]        i_asel,
    input  logic              i_bsel,
    input  logic [REG_AW-1:0] i_rd_addr,
    input  logic              i_rd_wren,
    input  logic              i_is_load,
    input  logic [REG_AW-1:0] i_mem_rd_addr,
    input  logic              i_mem_rd_wren,
    input  logic              i_mem_is_load,
    input  logic [XLEN-1:0]   i_mem_data,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    input  logic              i_wb_rd_wren,
    input  logic [XLEN-1:0]   i_wb_data,
    input  logic              i_ex_ready,
    output logic              o_ex_valid,
    output logic [XLEN-1:0]   o_op_a,
    output logic [XLEN-1:0]   o_op_b,
    output logic [3:0]        o_alu_op,
    output logic [XLEN-1:0]   o_store_data,
    output logic [REG_AW-1:0] o_rd_addr,
    output logic              o_rd_wren,
    output logic              o_is_load,
    output logic [XLEN-1:0]   o_pc,
    output logic              o_stall
);

`ifdef ALU_FWD_EN
    localparam bit REFRESH_ON_STALL = 1'b0;
`else
    localparam bit REFRESH_ON_STALL = 1'b1;
`endif

    ex_state_e         state_q, state_d;
    logic              valid_q;
    logic [XLEN-1:0]   pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [REG_AW-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
    alu_op_e           alu_op_q;
    asel_e             asel_q;
    bsel_e             bsel_q;
    logic              rd_wren_q, is_load_q;
    logic [XLEN-1:0]   rs1_fwd, rs2_fwd;
    logic              hazard_rs1, hazard_rs2, hazard;
    logic              capture, take, fire;

    fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr(rs1_addr_q), .rs_data(rs1_data_q),
        .mem_rd_addr(i_mem_rd_addr), .mem_rd_wren(i_mem_rd_wren),
        .mem_is_load(i_mem_is_load), .mem_data(i_mem_data),
        .wb_rd_addr(i_wb_rd_addr), .wb_rd_wren(i_wb_rd_wren), .wb_data(i_wb_data),
        .fwd_data(rs1_fwd), .hazard(hazard_rs1)
    );

    fwd_unit #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr(rs2_addr_q), .rs_data(rs2_data_q),
        .mem_rd_addr(i_mem_rd_addr), .mem_rd_wren(i_mem_rd_wren),
        .mem_is_load(i_mem_is_load), .mem_data(i_mem_data),
        .wb_rd_addr(i_wb_rd_addr), .wb_rd_wren(i_wb_rd_wren), .wb_data(i_wb_data),
        .fwd_data(rs2_fwd), .hazard(hazard_rs2)
    );

    assign valid_q    = (state_q != ST_EMPTY);
    assign hazard     = valid_q & (hazard_rs1 | hazard_rs2);
    assign o_ex_valid = valid_q & ~hazard;
    assign o_id_ready = ~valid_q | (i_ex_ready & ~hazard);
    assign o_stall    = hazard;
    assign capture    = i_id_valid & o_id_ready;
    // a redirect kills the incoming instruction as well as the held one
    assign take       = capture & ~i_flush;
    assign fire       = o_ex_valid & i_ex_ready;

    always_comb begin
        state_d = state_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY:     if (capture) state_d = ST_FULL;
                ST_FULL,
                ST_INTERLOCK: begin
                    if (hazard)    state_d = ST_INTERLOCK;
                    else if (fire) state_d = capture ? ST_FULL : ST_EMPTY;
                    else           state_d = ST_FULL;
                end
                default:      state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_EMPTY;
            pc_q       <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            alu_op_q   <= ALU_ADD;
            asel_q     <= ASEL_RS1;
            bsel_q     <= BSEL_RS2;
            rd_addr_q  <= '0;
            rd_wren_q  <= 1'b0;
            is_load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                pc_q       <= i_pc;
                rs1_addr_q <= i_rs1_addr;
                rs2_addr_q <= i_rs2_addr;
                rs1_data_q <= i_rs1_data;
                rs2_data_q <= i_rs2_data;
                imm_q      <= i_imm;
                alu_op_q   <= alu_op_e'(i_alu_op);
                asel_q     <= asel_e'(i_asel);
                bsel_q     <= bsel_e'(i_bsel);
                rd_addr_q  <= i_rd_addr;
                rd_wren_q  <= i_rd_wren;
                is_load_q  <= i_is_load;
            end else if (REFRESH_ON_STALL && hazard) begin
                // without bypass paths the write-through regfile delivers the producer's value
                rs1_data_q <= i_rs1_data;
                rs2_data_q <= i_rs2_data;
            end
        end
    end

    always_comb begin
        case (asel_q)
            ASEL_RS1: o_op_a = rs1_fwd;
            ASEL_PC:  o_op_a = pc_q;
            default:  o_op_a = '0;
        endcase
        o_op_b = (bsel_q == BSEL_IMM) ? imm_q : rs2_fwd;
    end

    assign o_store_data = rs2_fwd;
    assign o_alu_op     = alu_op_q;
    assign o_rd_addr    = rd_addr_q;
    assign o_rd_wren    = rd_wren_q & o_ex_valid;
    assign o_is_load    = is_load_q;
    assign o_pc         = pc_q;

endmodule
